// File: rtl/dualram_arbiter_if.sv
// Bundle of client handshakes, RAM command/return bus and the stall counter
// for dualram_arbiter. The arbiter binds to the slave modport; whoever plays
// the clients and the RAM binds to the master modport.
interface dualram_arbiter_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  w0_req_i;
  logic [ADDR_WIDTH-1:0] w0_addr_i;
  logic [WIDTH-1:0]      w0_data_i;
  logic                  w0_gnt_o;
  logic                  w1_req_i;
  logic [ADDR_WIDTH-1:0] w1_addr_i;
  logic [WIDTH-1:0]      w1_data_i;
  logic                  w1_gnt_o;

  logic                  r0_req_i;
  logic [ADDR_WIDTH-1:0] r0_addr_i;
  logic                  r0_gnt_o;
  logic                  r0_rvalid_o;
  logic [WIDTH-1:0]      r0_rdata_o;
  logic                  r1_req_i;
  logic [ADDR_WIDTH-1:0] r1_addr_i;
  logic                  r1_gnt_o;
  logic                  r1_rvalid_o;
  logic [WIDTH-1:0]      r1_rdata_o;

  logic                  ram_wr_en_o;
  logic [ADDR_WIDTH-1:0] ram_wr_addr_o;
  logic [WIDTH-1:0]      ram_wdata_o;
  logic                  ram_rd_en_o;
  logic [ADDR_WIDTH-1:0] ram_rd_addr_o;
  logic [WIDTH-1:0]      ram_rdata_i;

  logic [15:0]           stall_cnt_o;

  modport slave (
    input  w0_req_i, w0_addr_i, w0_data_i, w1_req_i, w1_addr_i, w1_data_i,
    input  r0_req_i, r0_addr_i, r1_req_i, r1_addr_i, ram_rdata_i,
    output w0_gnt_o, w1_gnt_o, r0_gnt_o, r1_gnt_o,
    output r0_rvalid_o, r0_rdata_o, r1_rvalid_o, r1_rdata_o,
    output ram_wr_en_o, ram_wr_addr_o, ram_wdata_o, ram_rd_en_o, ram_rd_addr_o,
    output stall_cnt_o
  );

  modport master (
    output w0_req_i, w0_addr_i, w0_data_i, w1_req_i, w1_addr_i, w1_data_i,
    output r0_req_i, r0_addr_i, r1_req_i, r1_addr_i, ram_rdata_i,
    input  w0_gnt_o, w1_gnt_o, r0_gnt_o, r1_gnt_o,
    input  r0_rvalid_o, r0_rdata_o, r1_rvalid_o, r1_rdata_o,
    input  ram_wr_en_o, ram_wr_addr_o, ram_wdata_o, ram_rd_en_o, ram_rd_addr_o,
    input  stall_cnt_o
  );
endinterface

// File: rtl/dualram_arbiter.sv
// Round-robin arbiter and sequencer in front of a dual-port RAM: two write
// clients share the write port, two read clients share the read port. Reads
// that hit the address being written in the same cycle are held back one
// cycle so they observe the new data. Returned data is steered back to the
// client that issued the read through a tagged latency pipeline.
module dualram_arbiter #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dualram_arbiter_if.slave   bus
);

  // Pointers hold the client granted last; 1 after reset so client 0 wins first.
  logic                  r_wPtr;
  logic                  r_rPtr;

  logic                  w_wGnt0;
  logic                  w_wGnt1;
  logic                  w_wAny;
  logic [ADDR_WIDTH-1:0] w_wAddr;
  logic [WIDTH-1:0]      w_wData;
  logic                  w_rWin0;
  logic                  w_rWin1;
  logic [ADDR_WIDTH-1:0] w_rAddr;
  logic                  w_collide;
  logic                  w_rGnt0;
  logic                  w_rGnt1;
  logic                  w_rAny;

  logic                  r_ramWrEn;
  logic [ADDR_WIDTH-1:0] r_ramWrAddr;
  logic [WIDTH-1:0]      r_ramWdata;
  logic                  r_ramRdEn;
  logic [ADDR_WIDTH-1:0] r_ramRdAddr;

  logic [RD_LAT:0]       r_pipeValid;
  logic [RD_LAT:0]       r_pipeId;
  logic                  r_rvalid0;
  logic                  r_rvalid1;
  logic [WIDTH-1:0]      r_rdata0;
  logic [WIDTH-1:0]      r_rdata1;
  logic [15:0]           r_stallCnt;

  // Grant decode for both ports plus write-first collision suppression of the read winner.
  always_comb begin
    w_wGnt0   = rst_i & bus.w0_req_i & (~bus.w1_req_i | r_wPtr);
    w_wGnt1   = rst_i & bus.w1_req_i & (~bus.w0_req_i | ~r_wPtr);
    w_wAny    = w_wGnt0 | w_wGnt1;
    w_wAddr   = w_wGnt1 ? bus.w1_addr_i : bus.w0_addr_i;
    w_wData   = w_wGnt1 ? bus.w1_data_i : bus.w0_data_i;
    w_rWin0   = rst_i & bus.r0_req_i & (~bus.r1_req_i | r_rPtr);
    w_rWin1   = rst_i & bus.r1_req_i & (~bus.r0_req_i | ~r_rPtr);
    w_rAddr   = w_rWin1 ? bus.r1_addr_i : bus.r0_addr_i;
    w_collide = (w_rWin0 | w_rWin1) & w_wAny & (w_rAddr == w_wAddr);
    w_rGnt0   = w_rWin0 & ~w_collide;
    w_rGnt1   = w_rWin1 & ~w_collide;
    w_rAny    = w_rGnt0 | w_rGnt1;
  end

  // Pointer update: move to the granted client; a suppressed read leaves it alone.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_wPtr <= 1'b1;
      r_rPtr <= 1'b1;
    end else begin
      if (w_wAny) r_wPtr <= w_wGnt1;
      if (w_rAny) r_rPtr <= w_rGnt1;
    end
  end

  // Register accepted transfers onto the RAM command bus for a single cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ramWrEn   <= 1'b0;
      r_ramWrAddr <= '0;
      r_ramWdata  <= '0;
      r_ramRdEn   <= 1'b0;
      r_ramRdAddr <= '0;
    end else begin
      r_ramWrEn <= w_wAny;
      r_ramRdEn <= w_rAny;
      if (w_wAny) begin
        r_ramWrAddr <= w_wAddr;
        r_ramWdata  <= w_wData;
      end
      if (w_rAny) r_ramRdAddr <= w_rAddr;
    end
  end

  // Tag each issued read with its client; stage RD_LAT lines up with valid RAM data.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_pipeValid <= '0;
      r_pipeId    <= '0;
    end else begin
      r_pipeValid <= {r_pipeValid[RD_LAT-1:0], w_rAny};
      r_pipeId    <= {r_pipeId[RD_LAT-1:0], w_rGnt1};
    end
  end

  // Capture matured RAM data into the owning client's output and pulse its rvalid.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= r_pipeValid[RD_LAT] & ~r_pipeId[RD_LAT];
      r_rvalid1 <= r_pipeValid[RD_LAT] & r_pipeId[RD_LAT];
      if (r_pipeValid[RD_LAT] && !r_pipeId[RD_LAT]) r_rdata0 <= bus.ram_rdata_i;
      if (r_pipeValid[RD_LAT] && r_pipeId[RD_LAT])  r_rdata1 <= bus.ram_rdata_i;
    end
  end

  // Count collision-deferred reads, sticking at all-ones.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_stallCnt <= '0;
    end else if (w_collide && (r_stallCnt != 16'hFFFF)) begin
      r_stallCnt <= r_stallCnt + 16'd1;
    end
  end

  assign bus.w0_gnt_o      = w_wGnt0;
  assign bus.w1_gnt_o      = w_wGnt1;
  assign bus.r0_gnt_o      = w_rGnt0;
  assign bus.r1_gnt_o      = w_rGnt1;
  assign bus.r0_rvalid_o   = r_rvalid0;
  assign bus.r1_rvalid_o   = r_rvalid1;
  assign bus.r0_rdata_o    = r_rdata0;
  assign bus.r1_rdata_o    = r_rdata1;
  assign bus.ram_wr_en_o   = r_ramWrEn;
  assign bus.ram_wr_addr_o = r_ramWrAddr;
  assign bus.ram_wdata_o   = r_ramWdata;
  assign bus.ram_rd_en_o   = r_ramRdEn;
  assign bus.ram_rd_addr_o = r_ramRdAddr;
  assign bus.stall_cnt_o   = r_stallCnt;

endmodule
